// File: rtl/mul_share_arb.sv
// Round-robin arbiter in front of one shared pipelined unsigned multiplier.
// Each result returns LATENCY non-stalled edges after acceptance, tagged with its requester.
module mul_share_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [2*W-1:0]       rsp_p,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(NREQ);
  localparam int unsigned PW = 2 * W;
  localparam int unsigned AW = $clog2(NREQ * W);

  logic [TW-1:0]      r_ptr;
  logic [TW-1:0]      w_gnt;
  logic [TW-1:0]      w_ptr_nxt;
  logic               w_found;
  logic               w_xfer;
  int unsigned        w_idx;
  logic [AW-1:0]      w_base;
  logic [W-1:0]       w_sel_a;
  logic [W-1:0]       w_sel_b;

  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] w_vld_nxt;
  logic [TW-1:0]      r_tag    [LATENCY];
  logic [TW-1:0]      w_tag_in [LATENCY];
  logic [PW-1:0]      r_dat    [LATENCY];
  logic [PW-1:0]      w_dat_in [LATENCY];
  logic               r_busy;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_idx = 32'(r_ptr) + off;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req_valid[TW'(w_idx)]) begin
        w_found = 1'b1;
        w_gnt   = TW'(w_idx);
      end
    end
  end

  assign w_xfer    = w_found & ~stall;
  assign req_ready = w_xfer ? (NREQ'(1) << w_gnt) : '0;
  assign w_ptr_nxt = (w_gnt == TW'(NREQ - 1)) ? '0 : w_gnt + TW'(1);
  assign w_base    = AW'(32'(w_gnt) * W);
  assign w_sel_a   = req_a[w_base +: W];
  assign w_sel_b   = req_b[w_base +: W];

  // Stage 0 keeps raw operands; the multiply sits between stages 0 and 1 unless there is only one stage.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_dat_in[0] = PW'(w_sel_a) * PW'(w_sel_b);
    end else begin : g_latn
      assign w_dat_in[0] = {w_sel_b, w_sel_a};
      assign w_dat_in[1] = PW'(r_dat[0][W-1:0]) * PW'(r_dat[0][PW-1:W]);
      for (genvar k = 2; k < LATENCY; k++) begin : g_cp
        assign w_dat_in[k] = r_dat[k-1];
      end
    end
  endgenerate

  always_comb begin
    w_vld_nxt   = r_vld;
    w_tag_in[0] = w_gnt;
    for (int unsigned k = 1; k < LATENCY; k++) w_tag_in[k] = r_tag[k-1];
    if (!stall) begin
      w_vld_nxt[0] = w_xfer;
      for (int unsigned k = 1; k < LATENCY; k++) w_vld_nxt[k] = r_vld[k-1];
    end
  end

  // Pipeline advances only when not stalled; payload loads only with a valid entry so rsp_p holds.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_ptr  <= '0;
      r_vld  <= '0;
      r_busy <= 1'b0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        r_tag[k] <= '0;
        r_dat[k] <= '0;
      end
    end else begin
      r_vld  <= w_vld_nxt;
      r_busy <= |w_vld_nxt;
      if (w_xfer) r_ptr <= w_ptr_nxt;
      if (!stall) begin
        for (int unsigned k = 0; k < LATENCY; k++) begin
          if (w_vld_nxt[k]) begin
            r_tag[k] <= w_tag_in[k];
            r_dat[k] <= w_dat_in[k];
          end
        end
      end
    end
  end

  assign rsp_valid = (r_vld[LATENCY-1] && !stall) ? (NREQ'(1) << r_tag[LATENCY-1]) : '0;
  assign rsp_p     = r_dat[LATENCY-1];
  assign busy      = r_busy;

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: a request-level model predicts grants and
// queues products; a monitor checks every cycle's handshake and responses.
module tb_mul_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 3;

  logic                clk = 1'b0;
  logic                resetq;
  logic                stall;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [2*W-1:0]      rsp_p;
  logic                busy;

  always #5 clk = ~clk;

  mul_share_arb #(.NREQ(NREQ), .W(W), .LATENCY(LAT)) dut (
    .clk(clk), .resetq(resetq), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
  );

  typedef struct {
    int          tag;
    logic [63:0] prod;
    int          n_acc;
  } exp_t;

  exp_t            sbq[$];
  int              checks   = 0;
  int              failures = 0;
  int              m_ptr    = 0;
  int              c_edges  = 0;
  logic [NREQ-1:0] acc_seen = '0;

  logic [NREQ-1:0] v_arr = '0;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int off = 0; off < NREQ; off++) begin
      int i;
      i = (p + off) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each non-stalled edge accepts the round-robin winner.
  always @(posedge clk) begin : model
    int g;
    if (!resetq) begin
      m_ptr = 0;
    end else if (!stall) begin
      g = model_grant(req_valid, m_ptr);
      if (g >= 0) begin
        sbq.push_back('{g, 64'(req_a[g*W +: W]) * 64'(req_b[g*W +: W]), c_edges + 1});
        m_ptr = (g + 1) % NREQ;
      end
      c_edges++;
    end
  end

  // Monitor: result due once LAT-1 further non-stalled edges have passed and the cycle is not stalled.
  always @(negedge clk) begin : monitor
    int              g;
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] ev;
    bit              due;
    if (!resetq) begin
      sbq.delete();
      acc_seen = '0;
    end else begin
      g  = stall ? -1 : model_grant(req_valid, m_ptr);
      er = (g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("busy", 64'(busy), 64'(sbq.size() != 0));
      if (sbq.size() > 0 && sbq[0].n_acc + LAT - 1 < c_edges) begin
        checks++;
        failures++;
        $display("FAIL rsp_missed: tag %0d product 0x%0h never delivered", sbq[0].tag, sbq[0].prod);
        void'(sbq.pop_front());
      end
      due = sbq.size() > 0 && sbq[0].n_acc + LAT - 1 == c_edges && !stall;
      ev  = due ? (NREQ'(1) << sbq[0].tag) : '0;
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (due) begin
        chk("rsp_p", rsp_p, sbq[0].prod);
        void'(sbq.pop_front());
      end
      acc_seen = req_valid & req_ready;
    end
  end

  task automatic drive();
    req_valid = v_arr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = a_arr[i];
      req_b[i*W +: W] = b_arr[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    v_arr = v_arr & ~acc_seen;
    drive();
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    v_arr[i] = 1'b1;
    a_arr[i] = a;
    b_arr[i] = b;
    drive();
  endtask

  task automatic apply_reset();
    resetq = 1'b0;
    v_arr  = '0;
    drive();
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_p", rsp_p, 64'd0);
    #11;
    resetq = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 64 && !idle; n++) begin
      if (v_arr == '0 && sbq.size() == 0) idle = 1'b1;
      else tick();
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL idle_timeout: pending=%0d outstanding=%0d", v_arr, sbq.size());
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    stall  = 1'b0;
    resetq = 1'b0;
    drive();
    #3;
    apply_reset();

    // Single op: explicit latency and all-ones product.
    issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 1;
    tick();
    while (rsp_valid == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("single_latency", 64'(n), 64'(LAT));
    chk("single_tag", 64'(rsp_valid), 64'h4);
    chk("single_p", rsp_p, 64'hFFFF_FFFE_0000_0001);
    wait_idle();

    // Round robin from ptr=0 with all requesters held valid.
    apply_reset();
    for (int i = 0; i < NREQ; i++) issue(i, 32'(i + 1), 32'h1_0000);
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (!v_arr[i]) issue(i, 32'(i + 1), 32'h1_0000);
    end
    v_arr = '0;
    drive();
    wait_idle();

    // Stall for four edges right after the accept edge.
    issue(0, 32'd3, 32'd5);
    tick();
    stall = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    stall = 1'b0;
    wait_idle();

    // Sparse fairness: ptr reaches 2, then requester 3 beats requester 1.
    issue(1, 32'd7, 32'd9);
    tick();
    issue(1, 32'd11, 32'd13);
    issue(3, 32'd17, 32'd19);
    tick();
    tick();
    wait_idle();

    // Zero and top-bit operands, back to back from different requesters.
    issue(0, 32'd0, 32'hDEAD_BEEF);
    issue(2, 32'd1, 32'h8000_0000);
    wait_idle();

    // Reset with two operations in flight: nothing may emerge afterwards.
    issue(1, 32'd100, 32'd200);
    issue(2, 32'd300, 32'd400);
    tick();
    tick();
    #2;
    apply_reset();
    for (int c = 0; c < 8; c++) tick();

    // Random traffic with random stalls.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v_arr[i] && ($urandom % 3) == 0) begin
          case ($urandom % 6)
            0:       issue(i, 32'hFFFF_FFFF, $urandom);
            1:       issue(i, 32'd0, $urandom);
            default: issue(i, $urandom, $urandom);
          endcase
        end
      end
      stall = (($urandom % 5) == 0);
      tick();
    end
    stall = 1'b0;
    for (int c = 0; c < 20 && v_arr != '0; c++) tick();
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
